// File: rtl/rr_merge4_pkg.sv
// Shared constants and types for the rr_merge4 four-to-one round-robin merger.
package rr_merge4_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 16;

    typedef logic [SEL_W-1:0] sel_t;

    // Channel index reached by stepping 'step' places upward from 'base', wrapping mod 4
    function automatic sel_t sel_add(input sel_t base, input int unsigned step);
        return sel_t'(base + sel_t'(step));
    endfunction

endpackage

// File: rtl/rr_merge4_arb.sv
// rr_arb4: four-way round-robin arbiter. Owns the priority pointer; the search
// starts at ptr and moves upward, wrapping from channel 3 back to channel 0.
// The pointer moves only when a grant is actually issued, so idle or stalled
// cycles leave priority unchanged.
module rr_arb4
    import rr_merge4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] req,
    input  logic              enable,
    output logic [CH_NUM-1:0] grant,
    output sel_t              idx
);

    sel_t ptr_q, ptr_d;
    sel_t cand;
    logic found;

    // First requester at or above ptr (mod 4); grant is gated by enable
    always_comb begin
        found = 1'b0;
        idx   = ptr_q;
        cand  = ptr_q;
        for (int k = 0; k < CH_NUM; k++) begin
            cand = sel_add(ptr_q, k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant = (enable && found) ? (CH_NUM'(1) << idx) : '0;
        ptr_d = (enable && found) ? sel_add(idx, 1) : ptr_q;
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rr_merge4.sv
// rr_merge4: four producer channels merged onto one registered output stream.
// Each output beat carries the 2-bit index of the channel it came from.
// The output register is a 1-deep buffer that reloads whenever it is empty or
// being drained in the same cycle, giving one beat per cycle with no bubbles.
// Optional feature: define RR_MERGE4_STATS_EN to add the beat_cnt port with
// saturating per-channel counters of delivered output beats.
module rr_merge4
    import rr_merge4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM*DATA_W-1:0] in_data,
    input  logic [CH_NUM-1:0]        in_valid,
    output logic [CH_NUM-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output sel_t                     out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef RR_MERGE4_STATS_EN
    ,
    output logic [CH_NUM*CNT_W-1:0]  beat_cnt
`endif
);

    logic [CH_NUM-1:0][DATA_W-1:0] in_vec;
    logic [CH_NUM-1:0]             grant;
    sel_t                          gidx;
    logic                          load_en;
    logic                          arb_en;
    logic                          take;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    sel_t              out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;

    assign in_vec  = in_data;
    assign load_en = !out_valid_q || out_ready;
    // rst_n gates the arbiter so no channel sees ready while reset is held
    assign arb_en  = load_en && rst_n;
    assign take    = |grant;

    rr_arb4 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (in_valid),
        .enable (arb_en),
        .grant  (grant),
        .idx    (gidx)
    );

    assign in_ready = grant;

    // Output buffer next state: load on grant, empty when drained with nothing to load
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_valid_d = take;
            if (take) begin
                out_data_d = in_vec[gidx];
                out_sel_d  = gidx;
            end
        end
    end

    // Output buffer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

`ifdef RR_MERGE4_STATS_EN
    logic [CH_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Count delivered beats per source channel, holding at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && out_ready && (cnt_q[out_sel_q] != {CNT_W{1'b1}}))
            cnt_d[out_sel_q] = cnt_q[out_sel_q] + CNT_W'(1);
    end

    // Beat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_merge4.sv
// Directed bench for rr_merge4: reset, single channel, full load rotation,
// backpressure, skip fairness, idle priority hold and (with
// RR_MERGE4_STATS_EN) the saturating beat counters.
module tb_rr_merge4;
    import rr_merge4_pkg::*;

    localparam int DATA_W = 8;

    logic                     clk;
    logic                     rst_n;
    logic [CH_NUM*DATA_W-1:0] in_data;
    logic [CH_NUM-1:0]        in_valid;
    logic [CH_NUM-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    sel_t                     out_sel;
    logic                     out_valid;
    logic                     out_ready;
`ifdef RR_MERGE4_STATS_EN
    logic [CH_NUM*CNT_W-1:0]  beat_cnt;
`endif

    int n_chk;
    int n_pass;

    rr_merge4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RR_MERGE4_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".sel"},   64'(out_sel),   64'(s));
    endtask

    initial begin
        logic [1:0] exp_s;
        logic [1:0] skip_seq [5];
        skip_seq = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
        n_chk = 0;
        n_pass = 0;

        // Reset with all channels requesting: nothing may be accepted
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset.in_ready", 64'(in_ready), 64'h0);
`ifdef RR_MERGE4_STATS_EN
        chk("reset.beat_cnt", 64'(beat_cnt), 64'h0);
`endif

        // Full load: strict rotation 0,1,2,3,... one beat per cycle
        rst_n = 1'b1;
        #1;
        chk("full.in_ready0", 64'(in_ready), 64'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_s = 2'(k);
            chk_out($sformatf("full%0d", k), 1'b1, 8'h10 + 8'(exp_s), exp_s);
            chk($sformatf("full%0d.in_ready", k), 64'(in_ready), 64'(4'b0001 << 2'(k + 1)));
        end

        // Reset mid-stream while holding a beat: clears immediately
        tick();
        chk("pre_rst.valid", 64'(out_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 8'h00, 2'd0);
        chk("mid_rst.in_ready", 64'(in_ready), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("post_rst", 1'b1, 8'h10, 2'd0);

        // Drain with no requesters: valid drops, data/sel hold
        in_valid = 4'b0000;
        tick();
        chk_out("idle", 1'b0, 8'h10, 2'd0);

        // Single channel 2
        in_valid = 4'b0100;
        set_data(8'h10, 8'h11, 8'hA5, 8'h13);
        #1;
        chk("single.in_ready", 64'(in_ready), 64'h4);
        tick();
        chk_out("single", 1'b1, 8'hA5, 2'd2);

        // Backpressure: beat held, nothing accepted
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", k), 64'(in_ready), 64'h0);
            tick();
            chk_out($sformatf("bp%0d", k), 1'b1, 8'hA5, 2'd2);
        end
        // Release: drain and reload in the same cycle, ptr was 3
        out_ready = 1'b1;
        #1;
        chk("bp_rel.in_ready", 64'(in_ready), 64'h8);
        tick();
        chk_out("bp_rel", 1'b1, 8'h13, 2'd3);

        // Skip fairness: ch1 and ch3 only, ptr now 0
        in_valid = 4'b1010;
        #1;
        chk("skip.in_ready", 64'(in_ready), 64'h2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("skip%0d", k), 1'b1, 8'h10 + 8'(skip_seq[k]), skip_seq[k]);
        end

        // Idle cycles must not rotate priority: ptr stays at 2
        in_valid = 4'b0000;
        tick();
        tick();
        chk("idle2.valid", 64'(out_valid), 64'h0);
        in_valid = 4'b1111;
        tick();
        chk_out("idle_prio", 1'b1, 8'h12, 2'd2);

`ifdef RR_MERGE4_STATS_EN
        // Fresh counters, then five beats from channel 2
        in_valid = 4'b0000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 4'b0100;
        for (int k = 0; k < 5; k++) tick();
        in_valid = 4'b0000;
        tick();
        chk("stats.ch2", 64'(beat_cnt[47:32]), 64'd5);
        chk("stats.ch0_zero", 64'(beat_cnt[15:0]), 64'd0);

        // 65540 beats from channel 0 saturate its counter
        in_valid = 4'b0001;
        for (int k = 0; k < 65540; k++) tick();
        in_valid = 4'b0000;
        tick();
        chk("stats.ch0_sat", 64'(beat_cnt[15:0]), 64'hFFFF);
        chk("stats.ch2_keep", 64'(beat_cnt[47:32]), 64'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
